// File: rtl/pe_pkg.sv
// Shared constants, the width sanity check and the saturating adder used by
// the output-stationary processing element.
package pe_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ACC_WIDTH  = 32;

  // Widest accumulator the saturating adder can handle.
  localparam int unsigned ACC_MAX_W = 64;

  // The accumulator must hold a full product and fit the adder.
  function automatic logic widths_ok(input int unsigned dw, input int unsigned aw);
    return (aw >= 2 * dw) && (aw <= ACC_MAX_W);
  endfunction

  localparam logic DEFAULT_WIDTHS_OK = widths_ok(DEFAULT_DATA_WIDTH, DEFAULT_ACC_WIDTH);

  typedef struct packed {
    logic [ACC_MAX_W-1:0] sum;
    logic                 ovf;
  } sat_add_t;

  // Adds two width-bit values (zero-padded to ACC_MAX_W). Signed mode flags
  // overflow on a sign flip of like-signed operands; unsigned mode flags the
  // carry out of bit width-1. With saturate set, the sum is clamped to the
  // limit in the direction of the overflow, otherwise it wraps.
  function automatic sat_add_t sat_add(input logic                 is_signed,
                                       input logic                 saturate,
                                       input int unsigned          width,
                                       input logic [ACC_MAX_W-1:0] x,
                                       input logic [ACC_MAX_W-1:0] y);
    sat_add_t             r;
    logic [ACC_MAX_W:0]   full;
    logic [ACC_MAX_W-1:0] top_bit;
    logic [ACC_MAX_W-1:0] mask;
    logic                 xs;
    logic                 ys;
    logic                 ss;
    logic                 carry;
    top_bit = ACC_MAX_W'(1) << (width - 1);
    mask    = (top_bit << 1) - ACC_MAX_W'(1);
    full    = {1'b0, x} + {1'b0, y};
    xs      = |(x & top_bit);
    ys      = |(y & top_bit);
    ss      = |(full[ACC_MAX_W-1:0] & top_bit);
    carry   = |(full & {top_bit, 1'b0});
    r.sum   = full[ACC_MAX_W-1:0] & mask;
    if (is_signed) begin
      r.ovf = (xs == ys) && (ss != xs);
      if (saturate && r.ovf) r.sum = xs ? top_bit : (mask & ~top_bit);
    end else begin
      r.ovf = carry;
      if (saturate && r.ovf) r.sum = mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational multiply-accumulate datapath: extends the product to the
// accumulator width, adds it to the (optionally restarted) accumulator and
// reports overflow of this single step.
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic                  restart,
  output logic [ACC_WIDTH-1:0]  acc_next,
  output logic                  ovf_now
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    prod_ext;
  logic [ACC_WIDTH-1:0]    base;
  sat_add_t                sum;

  // Product and its extension to the accumulator width, per operand signedness.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    prod     = '0;
    prod_ext = '0;
    if (SIGNED != 0) begin
      prod     = $unsigned((2*DATA_WIDTH)'($signed(a)) * (2*DATA_WIDTH)'($signed(b)));
      prod_ext = $unsigned(ACC_WIDTH'($signed(prod)));
    end else begin
      prod     = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
      prod_ext = ACC_WIDTH'(prod);
    end
  end

  // Accumulate onto zero for the first element of a tile, else onto acc.
  always_comb begin
    base     = restart ? '0 : acc;
    sum      = sat_add(SIGNED != 0, SATURATE != 0, ACC_WIDTH,
                       ACC_MAX_W'(base), ACC_MAX_W'(prod_ext));
    acc_next = sum.sum[ACC_WIDTH-1:0];
    ovf_now  = sum.ovf;
  end

endmodule

// File: rtl/pe_os_mac.sv
// Output-stationary systolic processing element: forwards operands right and
// down, accumulates one tile at a time and hands finished tiles to a
// column-wide result shift chain, parking a result when the chain is busy.
module pe_os_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_valid_in,
  input  logic                  a_first_in,
  input  logic                  a_last_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_valid_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_valid_out,
  output logic                  a_first_out,
  output logic                  a_last_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_valid_out,
  input  logic                  shift_en,
  input  logic [ACC_WIDTH-1:0]  res_in,
  input  logic                  res_valid_in,
  output logic [ACC_WIDTH-1:0]  res_out,
  output logic                  res_valid_out,
  output logic                  ovf,
  output logic                  err
);

  if (!widths_ok(DATA_WIDTH, ACC_WIDTH)) begin : g_width_check
    $error("pe_os_mac: ACC_WIDTH must be >= 2*DATA_WIDTH and <= ACC_MAX_W");
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_now;
  logic                 pend;
  logic [ACC_WIDTH-1:0] pend_val;
  logic                 fire;
  logic                 mismatch;
  logic                 capture;
  logic                 err_set;

  assign fire     = a_valid_in & b_valid_in;
  assign mismatch = a_valid_in ^ b_valid_in;
  assign capture  = fire & a_last_in;
  // Protocol errors: lone valid, a second result while one is parked, or a
  // direct capture that clobbers a result nobody has shifted out yet.
  assign err_set  = mismatch | (capture & pend) | (capture & ~shift_en & res_valid_out);

  pe_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED),
    .SATURATE  (SATURATE)
  ) u_mac (
    .a       (a_in),
    .b       (b_in),
    .acc     (acc),
    .restart (a_first_in),
    .acc_next(acc_next),
    .ovf_now (ovf_now)
  );

  // Unconditional one-cycle forwarding of operands and tile markers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      a_first_out <= 1'b0;
      a_last_out  <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      a_first_out <= a_first_in;
      a_last_out  <= a_last_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

  // Accumulator and per-tile overflow flag; the first element restarts both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (fire) begin
      acc <= acc_next;
      ovf <= a_first_in ? ovf_now : (ovf | ovf_now);
    end
  end

  // Result register: shifting wins, a capture during a shift is parked and
  // lands on the first idle cycle; a fresh capture supersedes a parked one.
  // NOTE: the parked value is a single register, so it is reset along with
  // everything else rather than left uninitialised like a memory would be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_out       <= '0;
      res_valid_out <= 1'b0;
      pend          <= 1'b0;
      pend_val      <= '0;
    end else if (shift_en) begin
      res_out       <= res_in;
      res_valid_out <= res_valid_in;
      if (capture) begin
        pend     <= 1'b1;
        pend_val <= acc_next;
      end
    end else if (capture) begin
      res_out       <= acc_next;
      res_valid_out <= 1'b1;
      pend          <= 1'b0;
    end else if (pend) begin
      res_out       <= pend_val;
      res_valid_out <= 1'b1;
      pend          <= 1'b0;
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule

// File: tb/tb_pe_os_mac.sv
// Directed bench for pe_os_mac: a signed 32-bit instance driven from a vector
// table, plus 16-bit unsigned saturating and wrapping instances for overflow.
module tb_pe_os_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        a_valid_in = 1'b0;
  logic        a_first_in = 1'b0;
  logic        a_last_in = 1'b0;
  logic        b_valid_in = 1'b0;
  logic        shift_en = 1'b0;
  logic [31:0] res_in = '0;
  logic        res_valid_in = 1'b0;

  always #5 clk = ~clk;

  // Signed, 32-bit, wrapping instance.
  logic [7:0]  s_a_out, s_b_out;
  logic        s_av, s_af, s_al, s_bv;
  logic [31:0] s_res;
  logic        s_rv, s_ovf, s_err;

  // Unsigned 16-bit saturating / wrapping instances.
  logic [7:0]  us_a_out, us_b_out, uw_a_out, uw_b_out;
  logic        us_av, us_af, us_al, us_bv, uw_av, uw_af, uw_al, uw_bv;
  logic [15:0] us_res, uw_res;
  logic        us_rv, us_ovf, us_err, uw_rv, uw_ovf, uw_err;

  pe_os_mac #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1), .SATURATE(0)) u_s (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_first_in(a_first_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(s_a_out), .a_valid_out(s_av), .a_first_out(s_af), .a_last_out(s_al),
    .b_out(s_b_out), .b_valid_out(s_bv),
    .shift_en(shift_en), .res_in(res_in), .res_valid_in(res_valid_in),
    .res_out(s_res), .res_valid_out(s_rv), .ovf(s_ovf), .err(s_err)
  );

  pe_os_mac #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1)) u_us (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_first_in(a_first_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(us_a_out), .a_valid_out(us_av), .a_first_out(us_af), .a_last_out(us_al),
    .b_out(us_b_out), .b_valid_out(us_bv),
    .shift_en(shift_en), .res_in(res_in[15:0]), .res_valid_in(res_valid_in),
    .res_out(us_res), .res_valid_out(us_rv), .ovf(us_ovf), .err(us_err)
  );

  pe_os_mac #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0)) u_uw (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_first_in(a_first_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(uw_a_out), .a_valid_out(uw_av), .a_first_out(uw_af), .a_last_out(uw_al),
    .b_out(uw_b_out), .b_valid_out(uw_bv),
    .shift_en(shift_en), .res_in(res_in[15:0]), .res_valid_in(res_valid_in),
    .res_out(uw_res), .res_valid_out(uw_rv), .ovf(uw_ovf), .err(uw_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a, b;
    logic        av, af, al, bv, sh;
    logic [31:0] rin;
    logic        rvin;
    logic [31:0] e_res;
    logic        e_rv, e_ovf, e_err;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic av, input logic af, input logic al,
                              input logic bv, input logic sh,
                              input logic [31:0] rin, input logic rvin,
                              input logic [31:0] e_res, input logic e_rv,
                              input logic e_ovf, input logic e_err);
    vec_t v;
    v.a = a; v.b = b; v.av = av; v.af = af; v.al = al; v.bv = bv; v.sh = sh;
    v.rin = rin; v.rvin = rvin;
    v.e_res = e_res; v.e_rv = e_rv; v.e_ovf = e_ovf; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a_in = v.a; b_in = v.b; a_valid_in = v.av; a_first_in = v.af; a_last_in = v.al;
    b_valid_in = v.bv; shift_en = v.sh; res_in = v.rin; res_valid_in = v.rvin;
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic v,
                         input logic f, input logic l, input logic sh);
    a_in = a; b_in = b; a_valid_in = v; b_valid_in = v; a_first_in = f; a_last_in = l;
    shift_en = sh; res_in = '0; res_valid_in = 1'b0;
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [19:0] fwd_exp;

  initial begin
    // Signed tile {3,-2,5}.{4,7,-1} = -7, then shift/pend, accumulation
    // continuing past a capture, and a lone-valid protocol error.
    vecs[0]  = mk(8'h03, 8'h04, 1, 1, 0, 1, 0, 32'h0,  0, 32'h0,        0, 0, 0);
    vecs[1]  = mk(8'hFE, 8'h07, 1, 0, 0, 1, 0, 32'h0,  0, 32'h0,        0, 0, 0);
    vecs[2]  = mk(8'h05, 8'hFF, 1, 0, 1, 1, 0, 32'h0,  0, 32'hFFFFFFF9, 1, 0, 0);
    vecs[3]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 32'h0,  0, 32'hFFFFFFF9, 1, 0, 0);
    vecs[4]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 32'h0,  0, 32'h0,        0, 0, 0);
    vecs[5]  = mk(8'h06, 8'h05, 1, 1, 1, 1, 1, 32'h11, 1, 32'h11,       1, 0, 0);
    vecs[6]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 32'h0,  0, 32'd30,       1, 0, 0);
    vecs[7]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 32'h0,  0, 32'h0,        0, 0, 0);
    vecs[8]  = mk(8'h01, 8'h02, 1, 0, 1, 1, 0, 32'h0,  0, 32'd32,       1, 0, 0);
    vecs[9]  = mk(8'h09, 8'h09, 1, 0, 1, 0, 0, 32'h0,  0, 32'd32,       1, 0, 1);
    vecs[10] = mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 32'h0,  0, 32'h0,        0, 0, 1);
    vecs[11] = mk(8'h01, 8'h01, 1, 0, 1, 1, 0, 32'h0,  0, 32'd33,       1, 0, 1);

    // Reset state.
    #2;
    check("reset res_out", 64'(s_res), 64'h0);
    check("reset flags", 64'({s_rv, s_ovf, s_err, s_av}), 64'h0);
    cycle();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      cycle();
      check($sformatf("vec%0d res_out", i), 64'(s_res), 64'(vecs[i].e_res));
      check($sformatf("vec%0d res_valid", i), 64'(s_rv), 64'(vecs[i].e_rv));
      check($sformatf("vec%0d ovf", i), 64'(s_ovf), 64'(vecs[i].e_ovf));
      check($sformatf("vec%0d err", i), 64'(s_err), 64'(vecs[i].e_err));
    end

    // Forwarding: every forward output is its input one cycle late.
    for (int i = 0; i < 50; i++) begin
      a_in = 8'($urandom); b_in = 8'($urandom);
      a_valid_in = 1'($urandom); b_valid_in = 1'($urandom);
      a_first_in = 1'($urandom); a_last_in = 1'($urandom);
      shift_en = 1'($urandom); res_in = $urandom; res_valid_in = 1'($urandom);
      fwd_exp = {a_in, a_valid_in, a_first_in, a_last_in, b_in, b_valid_in};
      cycle();
      check($sformatf("fwd%0d", i), 64'({s_a_out, s_av, s_af, s_al, s_b_out, s_bv}), 64'(fwd_exp));
    end

    // Asynchronous reset clears everything without a clock edge.
    rst = 1'b1;
    #1;
    check("async rst fwd", 64'({s_a_out, s_av, s_af, s_al, s_b_out, s_bv}), 64'h0);
    check("async rst res", 64'({s_res, s_rv, s_ovf, s_err}), 64'h0);
    check("async rst us", 64'({us_res, us_rv, us_ovf, us_err}), 64'h0);
    #1;
    rst = 1'b0;

    // Unsigned 16-bit overflow: 2 x 255*255 = 130050.
    set_ops(8'hFF, 8'hFF, 1, 1, 0, 0);
    cycle();
    set_ops(8'hFF, 8'hFF, 1, 0, 1, 0);
    cycle();
    check("sat res_out", 64'(us_res), 64'd65535);
    check("sat ovf", 64'(us_ovf), 64'h1);
    check("wrap res_out", 64'(uw_res), 64'd64514);
    check("wrap ovf", 64'(uw_ovf), 64'h1);
    set_ops(8'h01, 8'h01, 1, 1, 0, 0);
    cycle();
    check("sat ovf cleared", 64'(us_ovf), 64'h0);
    check("wrap ovf cleared", 64'(uw_ovf), 64'h0);

    // Two captures during shifting: second overwrites the parked one, err set.
    set_ops(8'h02, 8'h02, 1, 1, 1, 1);
    cycle();
    check("pend1 res_out", 64'(s_res), 64'h0);
    check("pend1 err", 64'(s_err), 64'h0);
    set_ops(8'h03, 8'h03, 1, 1, 1, 1);
    cycle();
    check("pend2 err", 64'(s_err), 64'h1);
    set_ops(8'h00, 8'h00, 0, 0, 0, 0);
    cycle();
    check("pend land res_out", 64'(s_res), 64'd9);
    check("pend land valid", 64'(s_rv), 64'h1);

    // Direct capture onto a valid, undrained result.
    rst = 1'b1; #1; rst = 1'b0;
    set_ops(8'h01, 8'h01, 1, 1, 1, 0);
    cycle();
    set_ops(8'h02, 8'h01, 1, 1, 1, 0);
    cycle();
    check("overwrite res_out", 64'(s_res), 64'd2);
    check("overwrite err", 64'(s_err), 64'h1);

    // Reset mid-tile, then a fresh tile 4*5 + (-3)*2 = 14.
    rst = 1'b1; #1; rst = 1'b0;
    set_ops(8'h02, 8'h03, 1, 1, 0, 0);
    cycle();
    check("midtile a_out", 64'(s_a_out), 64'h2);
    #2;
    rst = 1'b1;
    #1;
    check("midtile rst", 64'({s_a_out, s_res, s_rv, s_err, s_ovf}), 64'h0);
    #1;
    rst = 1'b0;
    set_ops(8'h04, 8'h05, 1, 1, 0, 0);
    cycle();
    set_ops(8'hFD, 8'h02, 1, 0, 1, 0);
    cycle();
    check("after rst res_out", 64'(s_res), 64'd14);
    check("after rst valid", 64'(s_rv), 64'h1);
    check("after rst err", 64'(s_err), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
